// File: rtl/irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared definitions for the parametrised interrupt controller:
//   - reg_addr_e     : register map on the 3-bit CPU register select
//   - STATUS_ANY_BIT : STATUS bit flagging "some enabled source pending"
//   - MAX_IRQS       : largest supported source count
//   - IDX_W          : width of the STATUS priority index field
// ---------------------------------------------------------------------------
package irq_ctrl_pkg;

    typedef enum logic [2:0] {
        REG_STATUS  = 3'd0,
        REG_BANK    = 3'd1,
        REG_ENABLE  = 3'd2,
        REG_PENDING = 3'd3,
        REG_MODE    = 3'd4,
        REG_RAW     = 3'd5,
        REG_EOI     = 3'd6,
        REG_CTRL    = 3'd7
    } reg_addr_e;

    localparam int STATUS_ANY_BIT = 7;
    localparam int MAX_IRQS       = 128;
    localparam int IDX_W          = $clog2(MAX_IRQS);

endpackage

// File: rtl/irq_edge_sync.sv
// ---------------------------------------------------------------------------
// irq_edge_sync
// Brings WIDTH asynchronous active-low lines into the clk domain through a
// 2-flop synchroniser and keeps one more "previous" stage so a falling edge
// can be strobed for one cycle. Every stage resets to 1 (line deasserted),
// so no spurious edge appears when reset is released.
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   async_n in   [WIDTH] raw active-low lines
//   sync_n  out  [WIDTH] synchronised active-low level
//   fall    out  [WIDTH] one-cycle strobe: previous=1 and current=0
// ---------------------------------------------------------------------------
module irq_edge_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_n,
    output logic [WIDTH-1:0] sync_n,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
            prev_q <= '1;
        end else begin
            meta_q <= async_n;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_n = sync_q;
    assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/irq_controller_n.sv
// ---------------------------------------------------------------------------
// irq_controller_n
// Aggregates NUM_IRQS active-low interrupt sources into one registered
// active-low CPU IRQ. Per-source enable, level/edge mode and edge-pending
// capture live in 8-bit banks reached through the BANK register; STATUS
// reports the lowest-index enabled pending source.
// Optional build macro: IRQC_SOFT_TRIGGER_EN -- when defined, a write to RAW
// sets the edge-pending flop of each written 1 bit that is in edge mode.
// Ports:
//   i_clk    in   CPU clock
//   i_rst_n  in   asynchronous active-low reset
//   i_cs     in   chip select
//   i_rwb    in   1 = read, 0 = write
//   i_addr   in   [3] register select
//   i_data   in   [8] write data
//   o_data   out  [8] read data (combinational)
//   i_irqb   in   [NUM_IRQS] active-low asynchronous sources
//   o_irqb   out  registered active-low master IRQ
// ---------------------------------------------------------------------------
module irq_controller_n
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQS = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cs,
    input  logic                i_rwb,
    input  logic [2:0]          i_addr,
    input  logic [7:0]          i_data,
    output logic [7:0]          o_data,
    input  logic [NUM_IRQS-1:0] i_irqb,
    output logic                o_irqb
);

    localparam int NUM_BANKS = NUM_IRQS / 8;
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [NUM_IRQS-1:0] sync_n;
    logic [NUM_IRQS-1:0] fall;
    logic [NUM_IRQS-1:0] raw;
    logic [NUM_IRQS-1:0] enable_q, enable_nxt;
    logic [NUM_IRQS-1:0] mode_q, mode_nxt;
    logic [NUM_IRQS-1:0] edge_pend_q, edge_pend_nxt;
    logic [NUM_IRQS-1:0] clr_mask, set_mask;
    logic [NUM_IRQS-1:0] pend_eff, active;
`ifdef IRQC_SOFT_TRIGGER_EN
    logic [NUM_IRQS-1:0] soft_mask;
`endif
    logic [BANK_W-1:0]   bank_sel_q;
    logic                bank_ok_q;
    logic                ctrl_en_q;
    logic                irqb_q;
    logic                wr;
    logic                any_pend;
    logic [IDX_W-1:0]    first_idx;
    logic [7:0]          sel_enable, sel_mode, sel_pend, sel_raw;

    irq_edge_sync #(.WIDTH(NUM_IRQS)) u_sync (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .async_n (i_irqb),
        .sync_n  (sync_n),
        .fall    (fall)
    );

    assign raw = ~sync_n;
    assign wr  = i_cs & ~i_rwb;

    // Level sources follow the synchronised line directly; edge sources
    // show the latched capture.
    assign pend_eff = (mode_q & edge_pend_q) | (~mode_q & raw);
    assign active   = pend_eff & enable_q;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        any_pend  = |active;
        first_idx = '0;
        for (int i = NUM_IRQS - 1; i >= 0; i--) begin
            if (active[i]) first_idx = IDX_W'(i);
        end
    end

    // Banked register writes and edge-pending clear/set masks. A bank that
    // is out of range matches no loop iteration, so its writes vanish.
    always_comb begin
        enable_nxt = enable_q;
        mode_nxt   = mode_q;
        clr_mask   = '0;
`ifdef IRQC_SOFT_TRIGGER_EN
        soft_mask  = '0;
`endif
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (wr && bank_ok_q && bank_sel_q == BANK_W'(b)) begin
                if (i_addr == REG_ENABLE)  enable_nxt[b*8 +: 8] = i_data;
                if (i_addr == REG_MODE)    mode_nxt[b*8 +: 8]   = i_data;
                if (i_addr == REG_PENDING) clr_mask[b*8 +: 8]   = i_data;
`ifdef IRQC_SOFT_TRIGGER_EN
                if (i_addr == REG_RAW)     soft_mask[b*8 +: 8]  = i_data;
`endif
            end
        end
        // A mode change discards any stale capture on that bit.
        clr_mask = clr_mask | (mode_q ^ mode_nxt);
        if (wr && i_addr == REG_EOI) begin
            for (int i = 0; i < NUM_IRQS; i++) begin
                if (i_data == 8'(i)) clr_mask[i] = 1'b1;
            end
        end
        // Captures are gated by the post-write mode so a level bit never
        // holds a latched edge.
        set_mask = fall & mode_nxt;
`ifdef IRQC_SOFT_TRIGGER_EN
        set_mask = set_mask | (soft_mask & mode_nxt);
`endif
        edge_pend_nxt = (edge_pend_q & ~clr_mask) | set_mask;
    end

    // Register state plus the registered master IRQ output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            enable_q    <= '0;
            mode_q      <= '0;
            edge_pend_q <= '0;
            bank_sel_q  <= '0;
            bank_ok_q   <= 1'b1;
            ctrl_en_q   <= 1'b0;
            irqb_q      <= 1'b1;
        end else begin
            enable_q    <= enable_nxt;
            mode_q      <= mode_nxt;
            edge_pend_q <= edge_pend_nxt;
            if (wr && i_addr == REG_BANK) begin
                bank_sel_q <= i_data[BANK_W-1:0];
                bank_ok_q  <= (i_data < 8'(NUM_BANKS));
            end
            if (wr && i_addr == REG_CTRL) ctrl_en_q <= i_data[0];
            irqb_q <= ~(ctrl_en_q & any_pend);
        end
    end

    assign o_irqb = irqb_q;

    // Slices of the currently selected bank; zero when the bank is invalid.
    always_comb begin
        sel_enable = 8'h00;
        sel_mode   = 8'h00;
        sel_pend   = 8'h00;
        sel_raw    = 8'h00;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_ok_q && bank_sel_q == BANK_W'(b)) begin
                sel_enable = enable_q[b*8 +: 8];
                sel_mode   = mode_q[b*8 +: 8];
                sel_pend   = pend_eff[b*8 +: 8];
                sel_raw    = raw[b*8 +: 8];
            end
        end
    end

    always_comb begin
        o_data = 8'h00;
        case (i_addr)
            REG_STATUS: begin
                o_data[IDX_W-1:0]      = first_idx;
                o_data[STATUS_ANY_BIT] = any_pend;
            end
            REG_BANK:    o_data[BANK_W-1:0] = (NUM_BANKS > 1) ? bank_sel_q : '0;
            REG_ENABLE:  o_data = sel_enable;
            REG_PENDING: o_data = sel_pend;
            REG_MODE:    o_data = sel_mode;
            REG_RAW:     o_data = sel_raw;
            REG_CTRL:    o_data[0] = ctrl_en_q;
            default:     o_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_controller_n.sv
// ---------------------------------------------------------------------------
// tb_irq_controller_n
// Directed bench for irq_controller_n at NUM_IRQS = 16. Each scenario task
// drives the bus / interrupt lines and compares against hand-derived values.
// ---------------------------------------------------------------------------
module tb_irq_controller_n;

    localparam int N = 16;

    logic         clk;
    logic         rst_n;
    logic         cs;
    logic         rwb;
    logic [2:0]   addr;
    logic [7:0]   data_w;
    logic [7:0]   data_r;
    logic [N-1:0] irqb;
    logic         irq_out;

    int total_cnt = 0;
    int pass_cnt  = 0;
    logic [7:0] rd;

    irq_controller_n #(.NUM_IRQS(N)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_cs    (cs),
        .i_rwb   (rwb),
        .i_addr  (addr),
        .i_data  (data_w),
        .o_data  (data_r),
        .i_irqb  (irqb),
        .o_irqb  (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus write: set up at the falling edge, commit on the rising edge.
    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rwb = 1'b0; addr = a; data_w = d;
        @(posedge clk);
        #1;
        cs = 1'b0; rwb = 1'b1; data_w = 8'h00;
    endtask

    // Reads are combinational and side-effect free; no clock edge needed.
    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        cs = 1'b1; rwb = 1'b1; addr = a;
        #1;
        d = data_r;
        cs = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cs = 1'b0; rwb = 1'b1; addr = 3'd0; data_w = 8'h00;
        irqb = '1;
        irqb[3] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (irq_out !== 1'b1) $display("[TB] FAIL irqb_in_reset: got %b want 1", irq_out);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (irq_out !== 1'b1) $display("[TB] FAIL irqb_after_reset: got %b want 1", irq_out);
        else pass_cnt++;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            total_cnt++;
            if (rd !== 8'h00) $display("[TB] FAIL reset_reg%0d: got %02h want 00", a, rd);
            else pass_cnt++;
        end
        repeat (10) @(posedge clk);
        #1;
        bus_read(3'd0, rd);
        total_cnt++;
        if (rd !== 8'h00) $display("[TB] FAIL reset_status_10cyc: got %02h want 00", rd);
        else pass_cnt++;
        total_cnt++;
        if (irq_out !== 1'b1) $display("[TB] FAIL reset_irqb_10cyc: got %b want 1", irq_out);
        else pass_cnt++;
        bus_read(3'd5, rd);
        total_cnt++;
        if (rd !== 8'h08) $display("[TB] FAIL reset_raw_sync: got %02h want 08", rd);
        else pass_cnt++;
        irqb[3] = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_level();
        bus_write(3'd2, 8'h08);
        bus_write(3'd7, 8'h01);
        repeat (3) @(posedge clk);
        @(negedge clk);
        irqb[3] = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (irq_out !== 1'b1) $display("[TB] FAIL level_k: got %b want 1", irq_out);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (irq_out !== 1'b1) $display("[TB] FAIL level_k1: got %b want 1", irq_out);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (irq_out !== 1'b0) $display("[TB] FAIL level_k2: got %b want 0", irq_out);
        else pass_cnt++;
        bus_read(3'd0, rd);
        total_cnt++;
        if (rd !== 8'h83) $display("[TB] FAIL level_status: got %02h want 83", rd);
        else pass_cnt++;
        @(negedge clk);
        irqb[3] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total_cnt++;
        if (irq_out !== 1'b0) $display("[TB] FAIL level_release_k1: got %b want 0", irq_out);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (irq_out !== 1'b1) $display("[TB] FAIL level_release_k2: got %b want 1", irq_out);
        else pass_cnt++;
    endtask

    task automatic test_edge();
        bus_write(3'd1, 8'h01);
        bus_write(3'd4, 8'h04);
        bus_write(3'd2, 8'h04);
        repeat (2) @(posedge clk);
        @(negedge clk);
        irqb[10] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        irqb[10] = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (irq_out !== 1'b1) $display("[TB] FAIL edge_k2: got %b want 1", irq_out);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (irq_out !== 1'b0) $display("[TB] FAIL edge_k3: got %b want 0", irq_out);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        bus_read(3'd3, rd);
        total_cnt++;
        if (rd !== 8'h04) $display("[TB] FAIL edge_pending_held: got %02h want 04", rd);
        else pass_cnt++;
        bus_read(3'd0, rd);
        total_cnt++;
        if (rd !== 8'h8A) $display("[TB] FAIL edge_status: got %02h want 8a", rd);
        else pass_cnt++;
        bus_write(3'd6, 8'h0A);
        total_cnt++;
        if (irq_out !== 1'b0) $display("[TB] FAIL eoi_same_edge: got %b want 0", irq_out);
        else pass_cnt++;
        bus_read(3'd3, rd);
        total_cnt++;
        if (rd !== 8'h00) $display("[TB] FAIL eoi_pending: got %02h want 00", rd);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (irq_out !== 1'b1) $display("[TB] FAIL eoi_irqb: got %b want 1", irq_out);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        bus_write(3'd2, 8'h10);
        bus_write(3'd1, 8'h00);
        bus_write(3'd2, 8'h20);
        @(negedge clk);
        irqb[5]  = 1'b0;
        irqb[12] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus_read(3'd0, rd);
        total_cnt++;
        if (rd !== 8'h85) $display("[TB] FAIL prio_both: got %02h want 85", rd);
        else pass_cnt++;
        total_cnt++;
        if (irq_out !== 1'b0) $display("[TB] FAIL prio_irqb: got %b want 0", irq_out);
        else pass_cnt++;
        bus_write(3'd2, 8'h00);
        bus_read(3'd0, rd);
        total_cnt++;
        if (rd !== 8'h8C) $display("[TB] FAIL prio_mask5: got %02h want 8c", rd);
        else pass_cnt++;
        @(negedge clk);
        irqb[5]  = 1'b1;
        irqb[12] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus_read(3'd0, rd);
        total_cnt++;
        if (rd !== 8'h00) $display("[TB] FAIL prio_released: got %02h want 00", rd);
        else pass_cnt++;
        total_cnt++;
        if (irq_out !== 1'b1) $display("[TB] FAIL prio_released_irqb: got %b want 1", irq_out);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bus_write(3'd1, 8'h01);
        bus_write(3'd2, 8'h04);
        @(negedge clk);
        irqb[10] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        irqb[10] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus_read(3'd3, rd);
        total_cnt++;
        if (rd !== 8'h04) $display("[TB] FAIL b2b_first_capture: got %02h want 04", rd);
        else pass_cnt++;
        bus_write(3'd3, 8'h04);
        bus_read(3'd3, rd);
        total_cnt++;
        if (rd !== 8'h00) $display("[TB] FAIL w1c_clear: got %02h want 00", rd);
        else pass_cnt++;
        // New edge lands in the same cycle as the W1C commit.
        @(negedge clk);
        irqb[10] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        bus_write(3'd3, 8'h04);
        bus_read(3'd3, rd);
        total_cnt++;
        if (rd !== 8'h04) $display("[TB] FAIL set_wins_clear: got %02h want 04", rd);
        else pass_cnt++;
        @(negedge clk);
        irqb[10] = 1'b1;
    endtask

    task automatic test_bank_range();
        bus_write(3'd1, 8'h07);
        bus_write(3'd2, 8'hFF);
        bus_read(3'd2, rd);
        total_cnt++;
        if (rd !== 8'h00) $display("[TB] FAIL oor_enable_read: got %02h want 00", rd);
        else pass_cnt++;
        bus_write(3'd1, 8'h01);
        bus_read(3'd2, rd);
        total_cnt++;
        if (rd !== 8'h04) $display("[TB] FAIL oor_write_ignored: got %02h want 04", rd);
        else pass_cnt++;
        bus_read(3'd1, rd);
        total_cnt++;
        if (rd !== 8'h01) $display("[TB] FAIL bank_readback: got %02h want 01", rd);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        repeat (3) @(posedge clk);
        #1;
        bus_read(3'd3, rd);
        total_cnt++;
        if (rd !== 8'h04) $display("[TB] FAIL pre_reset_pending: got %02h want 04", rd);
        else pass_cnt++;
        total_cnt++;
        if (irq_out !== 1'b0) $display("[TB] FAIL pre_reset_irqb: got %b want 0", irq_out);
        else pass_cnt++;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (irq_out !== 1'b1) $display("[TB] FAIL async_reset_irqb: got %b want 1", irq_out);
        else pass_cnt++;
        #1;
        rst_n = 1'b1;
        bus_read(3'd7, rd);
        total_cnt++;
        if (rd !== 8'h00) $display("[TB] FAIL async_reset_ctrl: got %02h want 00", rd);
        else pass_cnt++;
        bus_write(3'd1, 8'h01);
        bus_read(3'd3, rd);
        total_cnt++;
        if (rd !== 8'h00) $display("[TB] FAIL async_reset_pending: got %02h want 00", rd);
        else pass_cnt++;
`ifdef IRQC_SOFT_TRIGGER_EN
        bus_write(3'd4, 8'h04);
        bus_write(3'd2, 8'h04);
        bus_write(3'd7, 8'h01);
        bus_write(3'd5, 8'h10);
        bus_read(3'd3, rd);
        total_cnt++;
        if (rd !== 8'h00) $display("[TB] FAIL soft_level_ignored: got %02h want 00", rd);
        else pass_cnt++;
        bus_write(3'd5, 8'h04);
        bus_read(3'd0, rd);
        total_cnt++;
        if (rd !== 8'h8A) $display("[TB] FAIL soft_trigger_status: got %02h want 8a", rd);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (irq_out !== 1'b0) $display("[TB] FAIL soft_trigger_irqb: got %b want 0", irq_out);
        else pass_cnt++;
`else
        bus_write(3'd5, 8'h04);
        bus_read(3'd3, rd);
        total_cnt++;
        if (rd !== 8'h00) $display("[TB] FAIL raw_write_ignored: got %02h want 00", rd);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_priority();
        test_back_to_back();
        test_bank_range();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
